// File: rtl/pfvf_tx_arb_if.sv
// rtl/pfvf_tx_arb_if.sv - per-port TX streams and merged upstream AXI-S channel of the PF/VF TX arbiter
interface pfvf_tx_arb_if #(
    parameter int NUM_PORT = 4,
    parameter int TDATA_W  = 512,
    parameter int TUSER_W  = 10
);
    logic [NUM_PORT-1:0]         in_tvalid;
    logic [NUM_PORT-1:0]         in_tready;
    logic [NUM_PORT-1:0]         in_tlast;
    logic [NUM_PORT*TDATA_W-1:0] in_tdata;
    logic [NUM_PORT*TUSER_W-1:0] in_tuser;
    logic                        out_tvalid;
    logic                        out_tready;
    logic                        out_tlast;
    logic [TDATA_W-1:0]          out_tdata;
    logic [TUSER_W-1:0]          out_tuser;

    modport master (
        output in_tvalid, in_tlast, in_tdata, in_tuser, out_tready,
        input  in_tready, out_tvalid, out_tlast, out_tdata, out_tuser
    );

    modport slave (
        input  in_tvalid, in_tlast, in_tdata, in_tuser, out_tready,
        output in_tready, out_tvalid, out_tlast, out_tdata, out_tuser
    );
endinterface

// File: rtl/pfvf_tx_arb.sv
// rtl/pfvf_tx_arb.sv - packet-atomic weighted round-robin upstream TX arbiter; PFVF_TX_ARB_STATS_EN adds per-port packet counters
module pfvf_tx_arb #(
    parameter int  NUM_PORT   = 4,
    parameter int  TDATA_W    = 512,
    parameter int  TUSER_W    = 10,
    parameter int  BURST_PKTS = 2,
    localparam int SEL_W      = $clog2(NUM_PORT)
) (
    input  logic             clk,
    input  logic             rst,
    pfvf_tx_arb_if.slave     bus,
    output logic [SEL_W-1:0] out_sel,
    output logic             busy
`ifdef PFVF_TX_ARB_STATS_EN
    ,
    input  logic [SEL_W-1:0] stat_sel,
    output logic [31:0]      stat_pkts
`endif
);
    localparam int CNT_W = (BURST_PKTS > 1) ? $clog2(BURST_PKTS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t           state, state_d;
    logic [SEL_W-1:0] grant, grant_d;
    logic [SEL_W-1:0] last_srv, last_srv_d;
    logic [SEL_W-1:0] winner;
    logic [CNT_W-1:0] pkt_cnt, pkt_cnt_d;
    logic             granted;
    logic             eop;

    // Scan downward so the port closest after last_srv is written last and wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_PORT; i >= 1; i--) begin
            if (bus.in_tvalid[SEL_W'((int'(last_srv) + i) % NUM_PORT)])
                winner = SEL_W'((int'(last_srv) + i) % NUM_PORT);
        end
    end

    assign granted        = (state != IDLE);
    assign busy           = granted;
    assign out_sel        = granted ? grant : '0;
    assign bus.out_tvalid = granted & bus.in_tvalid[grant];
    assign bus.out_tlast  = granted & bus.in_tlast[grant];
    assign bus.out_tdata  = granted ? bus.in_tdata[grant*TDATA_W +: TDATA_W] : '0;
    assign bus.out_tuser  = granted ? bus.in_tuser[grant*TUSER_W +: TUSER_W] : '0;
    assign bus.in_tready  = granted ? (NUM_PORT'(bus.out_tready) << grant) : '0;
    assign eop            = bus.out_tvalid & bus.out_tready & bus.out_tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            last_srv <= SEL_W'(NUM_PORT - 1);
            pkt_cnt  <= '0;
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            last_srv <= last_srv_d;
            pkt_cnt  <= pkt_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        grant_d    = grant;
        last_srv_d = last_srv;
        pkt_cnt_d  = pkt_cnt;
        case (state)
            IDLE: begin
                if (|bus.in_tvalid) begin
                    grant_d   = winner;
                    pkt_cnt_d = '0;
                    state_d   = BUSY;
                end
            end
            BUSY, HOLD: begin
                // A silent port at a packet boundary gives up the rest of its burst.
                if (state == HOLD) begin
                    if (bus.in_tvalid[grant]) begin
                        state_d = BUSY;
                    end else begin
                        last_srv_d = grant;
                        state_d    = IDLE;
                    end
                end
                if (eop) begin
                    if (pkt_cnt == CNT_W'(BURST_PKTS - 1)) begin
                        last_srv_d = grant;
                        state_d    = IDLE;
                    end else begin
                        pkt_cnt_d = pkt_cnt + CNT_W'(1);
                        state_d   = HOLD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PFVF_TX_ARB_STATS_EN
    logic [31:0] pkt_stat [NUM_PORT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORT; p++) pkt_stat[p] <= '0;
            stat_pkts <= '0;
        end else begin
            if (eop && (pkt_stat[grant] != 32'hFFFF_FFFF))
                pkt_stat[grant] <= pkt_stat[grant] + 32'd1;
            stat_pkts <= (int'(stat_sel) < NUM_PORT) ? pkt_stat[stat_sel] : '0;
        end
    end
`endif
endmodule
